// File: rtl/meas_pkg.sv
// Shared state encoding and constants for the period-measurement front end.
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM         = 3'd1,
        WAIT_FIRST  = 3'd2,
        WAIT_SECOND = 3'd3,
        REPORT      = 3'd4
    } meas_state_t;

    localparam int unsigned TMO_W = 16;

endpackage

// File: rtl/meas_sync_filter.sv
// Synchroniser, glitch filter and single-cycle edge detector for the
// measured signal.
module meas_sync_filter
    import meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter bit          EDGE_RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic filt_level,
    output logic edge_evt
);

    localparam int unsigned   CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          fcnt;
    logic                   sync_lvl;
    logic                   filt_prev;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            fcnt       <= '0;
            filt_level <= 1'b0;
            filt_prev  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            filt_prev <= filt_level;
            // The level flips only after FILT_LEN consecutive disagreeing samples.
            if (sync_lvl == filt_level) begin
                fcnt <= '0;
            end else if (fcnt == CNT_LAST) begin
                filt_level <= ~filt_level;
                fcnt       <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign edge_evt = (filt_prev == ~EDGE_RISING) && (filt_level == EDGE_RISING);

endmodule

// File: rtl/meas_front_end.sv
// Front-end conditioner and two-edge sequencer for the period counter.
// Optional per-edge wait timeout enabled by defining MEAS_TIMEOUT_EN.
module meas_front_end
    import meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned PRESCALE    = 1,
    parameter bit          EDGE_RISING = 1'b1,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    input  logic start,
    input  logic abort,
    input  logic ack,
    input  logic done_in,
    output logic edge_pulse,
    output logic cnt_en,
    output logic done_clr,
    output logic busy,
    output logic result_valid,
`ifdef MEAS_TIMEOUT_EN
    output logic timeout,
`endif
    output logic filt_level
);

    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || PRESCALE < 1 ||
        TIMEOUT < 1 || TIMEOUT >= (32'd1 << TMO_W)) begin : g_param_check
        $error("meas_front_end: parameter out of range");
    end

    meas_state_t   state, state_d;
    logic [PW-1:0] presc, presc_d;
    logic          edge_evt;
    logic          edge_d, cnt_en_d, done_clr_d;
    logic          tmo_hit;

    meas_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .EDGE_RISING (EDGE_RISING)
    ) u_sync_filter (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .filt_level (filt_level),
        .edge_evt   (edge_evt)
    );

`ifdef MEAS_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] wcnt, wcnt_d;
    logic             timeout_d;
    logic             waiting;

    assign waiting = (state == WAIT_FIRST) || (state == WAIT_SECOND);
    assign tmo_hit = waiting && !edge_evt && (wcnt == TMO_LAST);

    always_comb begin
        wcnt_d    = (waiting && (state_d == state)) ? wcnt + 1'b1 : '0;
        timeout_d = timeout;
        if (state == IDLE && start) begin
            timeout_d = 1'b0;
        end else if (tmo_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            wcnt    <= wcnt_d;
            timeout <= timeout_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Strobes are computed from the next state and registered, so every
    // output appears one clock after the event that caused it.
    always_comb begin
        state_d    = state;
        edge_d     = 1'b0;
        done_clr_d = 1'b0;
        presc_d    = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    done_clr_d = 1'b1;
                end
            end
            ARM: state_d = WAIT_FIRST;
            WAIT_FIRST: begin
                if (edge_evt) begin
                    state_d = WAIT_SECOND;
                    edge_d  = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (edge_evt) begin
                    state_d = REPORT;
                    edge_d  = 1'b1;
                end else begin
                    presc_d = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                end
            end
            REPORT: begin
                if (ack && done_in) begin
                    state_d    = IDLE;
                    done_clr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state != IDLE && (abort || tmo_hit)) begin
            state_d    = IDLE;
            edge_d     = 1'b0;
            done_clr_d = 1'b1;
        end
        cnt_en_d = (state_d == WAIT_SECOND) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            presc      <= '0;
            edge_pulse <= 1'b0;
            cnt_en     <= 1'b0;
            done_clr   <= 1'b0;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            edge_pulse <= edge_d;
            cnt_en     <= cnt_en_d;
            done_clr   <= done_clr_d;
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == REPORT);

endmodule

// File: tb/tb_meas_front_end.sv
// Directed self-checking bench for meas_front_end (default and PRESCALE=4 instances).
`timescale 1ns/1ps
module tb_meas_front_end;

    logic clk = 1'b0;
    logic rst, sig_in, start, abort, ack, done_in;
    logic a_edge, a_cnt, a_clr, a_busy, a_rv, a_filt;
    logic b_edge, b_cnt, b_clr, b_busy, b_rv, b_filt;
`ifdef MEAS_TIMEOUT_EN
    logic a_tmo, b_tmo;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    meas_front_end dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .start        (start),
        .abort        (abort),
        .ack          (ack),
        .done_in      (done_in),
        .edge_pulse   (a_edge),
        .cnt_en       (a_cnt),
        .done_clr     (a_clr),
        .busy         (a_busy),
        .result_valid (a_rv),
`ifdef MEAS_TIMEOUT_EN
        .timeout      (a_tmo),
`endif
        .filt_level   (a_filt)
    );

    meas_front_end #(.PRESCALE(4), .TIMEOUT(50)) dut_p4 (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .start        (start),
        .abort        (abort),
        .ack          (ack),
        .done_in      (done_in),
        .edge_pulse   (b_edge),
        .cnt_en       (b_cnt),
        .done_clr     (b_clr),
        .busy         (b_busy),
        .result_valid (b_rv),
`ifdef MEAS_TIMEOUT_EN
        .timeout      (b_tmo),
`endif
        .filt_level   (b_filt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0; sig_in = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0; done_in = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
    endtask

    // Start pulse, then one cycle of ARM: both instances end up in WAIT_FIRST.
    task automatic begin_measure;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        start = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (a_edge !== 1'b0) begin errors++; $display("FAIL reset_edge_pulse: got %b expected 0", a_edge); end
        checks++; if (a_cnt !== 1'b0) begin errors++; $display("FAIL reset_cnt_en: got %b expected 0", a_cnt); end
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL reset_done_clr: got %b expected 0", a_clr); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", a_rv); end
        checks++; if (a_filt !== 1'b0) begin errors++; $display("FAIL reset_filt_level: got %b expected 0", a_filt); end
        repeat (2) tick;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy: got %b expected 0", a_busy); end
        start = 1'b0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int first, second, npulse, ncnt;
        apply_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL start_done_clr: got %b expected 1", a_clr); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", a_busy); end
        tick;
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL done_clr_width: got %b expected 0", a_clr); end
        sig_in = 1'b1;
        first = 0; second = 0; npulse = 0; ncnt = 0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            tick;
            if (a_edge) begin
                npulse++;
                if (first == 0) first = cyc; else second = cyc;
            end
            if (a_cnt) ncnt++;
            if (cyc == 50) sig_in = 1'b0;
            if (cyc == 100) sig_in = 1'b1;
        end
        checks++; if (first !== 7) begin errors++; $display("FAIL first_edge_latency: got cyc %0d expected 7", first); end
        checks++; if (second !== 107) begin errors++; $display("FAIL second_edge_time: got cyc %0d expected 107", second); end
        checks++; if (npulse !== 2) begin errors++; $display("FAIL pulse_count: got %0d expected 2", npulse); end
        checks++; if (ncnt !== 100) begin errors++; $display("FAIL cnt_en_cycles: got %0d expected 100", ncnt); end
        checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL report_result_valid: got %b expected 1", a_rv); end
        checks++; if (a_filt !== 1'b1) begin errors++; $display("FAIL filt_level_high: got %b expected 1", a_filt); end
    endtask

    task automatic test_report_handshake;
        done_in = 1'b0; ack = 1'b1;
        tick;
        ack = 1'b0;
        checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL ack_no_done_rv: got %b expected 1", a_rv); end
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL ack_no_done_clr: got %b expected 0", a_clr); end
        done_in = 1'b1;
        tick;
        checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL done_no_ack_rv: got %b expected 1", a_rv); end
        ack = 1'b1;
        tick;
        ack = 1'b0; done_in = 1'b0;
        checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL ack_done_clr: got %b expected 1", a_clr); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ack_busy: got %b expected 0", a_busy); end
        checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL ack_result_valid: got %b expected 0", a_rv); end
        tick;
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL ack_clr_width: got %b expected 0", a_clr); end
    endtask

    task automatic test_glitch;
        int npulse, nfilt;
        apply_reset;
        begin_measure;
        sig_in = 1'b1;
        repeat (3) tick;
        sig_in = 1'b0;
        npulse = 0; nfilt = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (a_edge) npulse++;
            if (a_filt) nfilt++;
        end
        checks++; if (npulse !== 0) begin errors++; $display("FAIL glitch3_pulses: got %0d expected 0", npulse); end
        checks++; if (nfilt !== 0) begin errors++; $display("FAIL glitch3_filt_cycles: got %0d expected 0", nfilt); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL glitch3_busy: got %b expected 1", a_busy); end
        sig_in = 1'b1;
        repeat (4) tick;
        sig_in = 1'b0;
        npulse = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (a_edge) npulse++;
        end
        checks++; if (npulse !== 1) begin errors++; $display("FAIL pulse4_pulses: got %0d expected 1", npulse); end
        checks++; if (a_filt !== 1'b0) begin errors++; $display("FAIL pulse4_filt_back: got %b expected 0", a_filt); end
    endtask

    task automatic test_prescale;
        int first, second, npulse, ncnt;
        apply_reset;
        begin_measure;
        sig_in = 1'b1;
        first = 0; second = 0; npulse = 0; ncnt = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick;
            if (b_edge) begin
                npulse++;
                if (first == 0) first = cyc; else second = cyc;
            end else if (first != 0 && second == 0 && b_cnt) begin
                ncnt++;
            end
            if (cyc == 20) sig_in = 1'b0;
            if (cyc == 40) sig_in = 1'b1;
        end
        checks++; if (first !== 7) begin errors++; $display("FAIL p4_first_edge: got cyc %0d expected 7", first); end
        checks++; if (second !== 47) begin errors++; $display("FAIL p4_second_edge: got cyc %0d expected 47", second); end
        checks++; if (npulse !== 2) begin errors++; $display("FAIL p4_pulse_count: got %0d expected 2", npulse); end
        checks++; if (ncnt !== 10) begin errors++; $display("FAIL p4_cnt_en_pulses: got %0d expected 10", ncnt); end
        checks++; if (b_rv !== 1'b1) begin errors++; $display("FAIL p4_result_valid: got %b expected 1", b_rv); end
    endtask

    task automatic test_abort;
        int npulse;
        apply_reset;
        begin_measure;
        sig_in = 1'b1;
        npulse = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick;
            if (a_edge) npulse++;
            if (cyc == 21) begin
                checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL busy_start_clr: got %b expected 0", a_clr); end
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b expected 1", a_busy); end
            end
            if (cyc == 47) begin
                checks++; if (a_edge !== 1'b0) begin errors++; $display("FAIL abort_edge_pulse: got %b expected 0", a_edge); end
                checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL abort_done_clr: got %b expected 1", a_clr); end
                checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", a_busy); end
                checks++; if (a_cnt !== 1'b0) begin errors++; $display("FAIL abort_cnt_en: got %b expected 0", a_cnt); end
            end
            if (cyc == 20) begin start = 1'b1; sig_in = 1'b0; end
            if (cyc == 21) start = 1'b0;
            if (cyc == 40) sig_in = 1'b1;
            if (cyc == 46) abort = 1'b1;
            if (cyc == 47) abort = 1'b0;
        end
        checks++; if (npulse !== 1) begin errors++; $display("FAIL abort_pulse_count: got %0d expected 1", npulse); end
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL idle_start_abort_busy: got %b expected 1", a_busy); end
        checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL idle_start_abort_clr: got %b expected 1", a_clr); end
    endtask

    task automatic test_async_reset;
        int nact;
        apply_reset;
        begin_measure;
        sig_in = 1'b1;
        repeat (20) tick;
        checks++; if (a_cnt !== 1'b1) begin errors++; $display("FAIL pre_reset_cnt_en: got %b expected 1", a_cnt); end
        #2 rst = 1'b0;
        #1;
        checks++; if (a_cnt !== 1'b0) begin errors++; $display("FAIL async_cnt_en: got %b expected 0", a_cnt); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", a_busy); end
        checks++; if (a_filt !== 1'b0) begin errors++; $display("FAIL async_filt_level: got %b expected 0", a_filt); end
        checks++; if (a_clr !== 1'b0) begin errors++; $display("FAIL async_done_clr: got %b expected 0", a_clr); end
        tick;
        rst = 1'b1;
        nact = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick;
            if (a_edge || a_cnt || a_busy) nact++;
            if (cyc == 10) sig_in = 1'b0;
            if (cyc == 20) sig_in = 1'b1;
        end
        checks++; if (nact !== 0) begin errors++; $display("FAIL post_reset_activity: got %0d cycles expected 0", nact); end
    endtask

`ifdef MEAS_TIMEOUT_EN
    task automatic test_timeout;
        int k;
        apply_reset;
        begin_measure;
        k = 0;
        while (b_busy && k < 80) begin
            tick;
            k++;
        end
        checks++; if (k !== 50) begin errors++; $display("FAIL timeout_cycles: got %0d expected 50", k); end
        checks++; if (b_tmo !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", b_tmo); end
        checks++; if (b_clr !== 1'b1) begin errors++; $display("FAIL timeout_done_clr: got %b expected 1", b_clr); end
        checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL long_timeout_flag: got %b expected 0", a_tmo); end
        tick;
        checks++; if (b_tmo !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", b_tmo); end
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (b_tmo !== 1'b0) begin errors++; $display("FAIL timeout_clear_on_start: got %b expected 0", b_tmo); end
    endtask
`endif

    initial begin
        rst = 1'b1; sig_in = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0; done_in = 1'b0;
        test_reset;
        test_basic;
        test_report_handshake;
        test_glitch;
        test_prescale;
        test_abort;
        test_async_reset;
`ifdef MEAS_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
